mult_div_ctrl: RTL

Multicycle sequencer for the CPU's shared multiply/divide resource and its HI/LO register pair. The control unit launches an operation with a one-cycle `MultCtrl` or `DivCtrl` pulse and stalls on `busy`. The block runs a radix-2 Booth multiply or a signed restoring divide, one iteration per clock. It loads HI/LO on completion and pulses `done`; the datapath reads `HI`/`LO` for MFHI/MFLO.

---
 rtl/mult_div_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multicycle sequencer for the shared multiply/divide unit and HI/LO.
// Runs a radix-2 Booth signed multiply or a signed restoring divide, one iteration
// per clock, then loads HI/LO and pulses done.
// Optional feature macro: MULT_DIV_DIVZERO_EXC_EN (drive div_zero on divide by zero;
// when undefined the div_zero port is tied low).
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic          dz;

  // acc/q double as remainder/quotient during a divide; m holds the
  // sign-extended multiplicand or the divisor magnitude. The extra acc bit
  // keeps Booth correct when the multiplicand is the most negative value.
  logic signed [WIDTH:0] acc;
  logic signed [WIDTH:0] m;
  logic [WIDTH-1:0]      q;
  logic                  q1;
  logic                  neg_q;
  logic                  neg_r;

  logic             accept;
  logic             start_mult;
  logic             start_div;
  logic             last_iter;
  logic             load_res;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    if (v[WIDTH-1]) return -v;
    return v;
  endfunction

  // One Booth step: add/subtract by {Q0,Q-1}, then arithmetic shift right of {acc,Q,Q-1}.
  function automatic logic [2*WIDTH+1:0] booth_step(
    input logic signed [WIDTH:0] a,
    input logic [WIDTH-1:0]      qq,
    input logic                  qm1,
    input logic signed [WIDTH:0] mm
  );
    logic signed [WIDTH:0] s;
    s = a;
    if ({qq[0], qm1} == 2'b01)      s = a + mm;
    else if ({qq[0], qm1} == 2'b10) s = a - mm;
    return {s[WIDTH], s, qq};
  endfunction

  // One restoring-divide step on magnitudes: shift, trial subtract, restore on borrow.
  function automatic logic [2*WIDTH:0] div_step(
    input logic [WIDTH:0]   r,
    input logic [WIDTH-1:0] qq,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;
    r_sh  = {r[WIDTH-1:0], qq[WIDTH-1]};
    trial = r_sh - {1'b0, d};
    if (trial[WIDTH]) return {r_sh, qq[WIDTH-2:0], 1'b0};
    return {trial, qq[WIDTH-2:0], 1'b1};
  endfunction

  // FINISH also accepts a start so a new operation can launch in the done cycle.
  assign accept     = (state == IDLE) || (state == FINISH);
  assign start_mult = accept && MultCtrl;
  assign start_div  = accept && !MultCtrl && DivCtrl;
  assign last_iter  = (cnt == LAST);
  assign load_res   = ((state == MULT) || (state == DIV && !dz)) && last_iter;

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE, FINISH: begin
        if (MultCtrl)     next_state = MULT;
        else if (DivCtrl) next_state = DIV;
        else              next_state = IDLE;
      end
      MULT:    if (last_iter) next_state = FINISH;
      DIV:     if (dz || last_iter) next_state = FINISH;
      default: next_state = IDLE;
    endcase
  end

  // Sign correction of the final result: quotient by operand signs, remainder by dividend sign
  always_comb begin
    res_hi = acc[WIDTH-1:0];
    res_lo = q;
    if (state == DIV) begin
      res_lo = neg_q ? -q : q;
      res_hi = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  // Control state, iteration counter, status flags and the HI/LO result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == MULT) || (next_state == DIV);
      done  <= (next_state == FINISH);
      if (start_mult || start_div)                      cnt <= '0;
      else if ((state == MULT || state == DIV) && !last_iter) cnt <= cnt + 1'b1;
      if (start_mult)     dz <= 1'b0;
      else if (start_div) dz <= (B == '0);
      if (load_res) begin
        HI <= res_hi;
        LO <= res_lo;
      end
    end
  end

  // Operand capture and one multiply/divide iteration per clock
  always_ff @(posedge clk) begin
    if (start_mult) begin
      acc <= '0;
      m   <= {A[WIDTH-1], A};
      q   <= B;
      q1  <= 1'b0;
    end else if (start_div) begin
      acc   <= '0;
      m     <= {1'b0, mag(B)};
      q     <= mag(A);
      neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
      neg_r <= A[WIDTH-1];
    end else if (state == MULT && !last_iter) begin
      {acc, q, q1} <= booth_step(acc, q, q1, m);
    end else if (state == DIV && !dz && !last_iter) begin
      {acc, q} <= div_step(acc, q, m[WIDTH-1:0]);
    end
  end

`ifdef MULT_DIV_DIVZERO_EXC_EN
  // Divide-by-zero flag pulses together with done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_zero <= 1'b0;
    else        div_zero <= (state == DIV) && dz;
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule
